fifo_sync_flags: RTL and testbench

//  Parametrised single-clock FIFO with full/empty, programmable almost-full/almost-empty,

---
 rtl/fifo_sync_flags_if.sv | 32 +++
 rtl/fifo_sync_flags.sv | 119 +++++++++++
 tb/tb_fifo_sync_flags.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_flags_if.sv
// Handshake and status bundle for fifo_sync_flags.
// The master drives push/pop/clear; the slave (the FIFO) returns data and status.
interface fifo_sync_flags_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  logic                       clear;
  logic                       wr_en;
  logic [WIDTH-1:0]           wr_data;
  logic                       rd_en;
  logic [WIDTH-1:0]           rd_data;
  logic                       rd_valid;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow and a choice of registered or fall-through read port.
module fifo_sync_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 2,
  parameter bit          FWFT      = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_sync_flags_if.slave   bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL    = CNT_W'(AE_THRESH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, underflow_q;
  logic              full, empty;
  logic              rd_acc, wr_acc;

  // Status flags decode straight from the registered occupancy.
  always_comb begin
    full  = (count_q == DEPTH_LVL);
    empty = (count_q == '0);
  end

  // Accept decisions on pre-edge state; a pop frees a slot for a same-cycle push.
  always_comb begin
    rd_acc  = bus.rd_en & ~empty;
    wr_acc  = bus.wr_en & (~full | rd_acc);
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clear) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Pointers, occupancy and sticky error flags; clear outranks any same-cycle request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      if (bus.wr_en && !wr_acc) overflow_q  <= 1'b1;
      if (bus.rd_en && empty)   underflow_q <= 1'b1;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word shown combinationally; masked while empty so the port never shows
    // an unwritten location.
    always_comb begin
      bus.rd_valid = ~empty;
      bus.rd_data  = empty ? '0 : mem[rd_ptr_q];
    end
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // Registered read: popped word appears the cycle after the request, data holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (bus.clear) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr_q];
      end
    end

    // Drive the registered read port.
    always_comb begin
      bus.rd_data  = rd_data_q;
      bus.rd_valid = rd_valid_q;
    end
  end

  // Export status.
  always_comb begin
    bus.full         = full;
    bus.empty        = empty;
    bus.almost_full  = (count_q >= AF_LVL);
    bus.almost_empty = (count_q <= AE_LVL);
    bus.count        = count_q;
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench: one registered-read and one fall-through FIFO driven in lockstep, checked each
// cycle against a queue model, plus hand-computed spot values.
module tb_fifo_sync_flags;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 12;
  localparam int unsigned AE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_en = 1'b0;

  int checks = 0;
  int failures = 0;

  fifo_sync_flags_if #(.WIDTH(W), .DEPTH(D)) if0 ();
  fifo_sync_flags_if #(.WIDTH(W), .DEPTH(D)) if1 ();

  assign if0.clear = clear;
  assign if0.wr_en = wr_en;
  assign if0.wr_data = wr_data;
  assign if0.rd_en = rd_en;
  assign if1.clear = clear;
  assign if1.wr_en = wr_en;
  assign if1.wr_data = wr_data;
  assign if1.rd_en = rd_en;

  fifo_sync_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  fifo_sync_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue plus sticky bits and the registered read port.
  logic [W-1:0] mq[$];
  bit           m_ovf, m_unf, m_v0;
  logic [W-1:0] m_d0;

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_v0  = 1'b0;
    m_d0  = '0;
  endtask

  task automatic model_step();
    bit m_full, m_empty, racc, wacc;
    if (clear) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_v0  = 1'b0;
      return;
    end
    m_full  = (mq.size() == D);
    m_empty = (mq.size() == 0);
    racc = rd_en && !m_empty;
    wacc = wr_en && (!m_full || racc);
    if (wr_en && !wacc) m_ovf = 1'b1;
    if (rd_en && m_empty) m_unf = 1'b1;
    if (racc) begin
      m_d0 = mq.pop_front();
      m_v0 = 1'b1;
    end else begin
      m_v0 = 1'b0;
    end
    if (wacc) mq.push_back(wr_data);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every negedge: both DUTs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("count0", 32'(if0.count), mq.size());
      chk("count1", 32'(if1.count), mq.size());
      chk("full", 32'(if0.full), 32'(mq.size() == D));
      chk("empty", 32'(if0.empty), 32'(mq.size() == 0));
      chk("almost_full", 32'(if0.almost_full), 32'(mq.size() >= AF));
      chk("almost_empty", 32'(if0.almost_empty), 32'(mq.size() <= AE));
      chk("overflow", 32'(if0.overflow), 32'(m_ovf));
      chk("underflow", 32'(if0.underflow), 32'(m_unf));
      chk("rd_valid0", 32'(if0.rd_valid), 32'(m_v0));
      chk("rd_data0", 32'(if0.rd_data), 32'(m_d0));
      chk("rd_valid1", 32'(if1.rd_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("rd_data1", 32'(if1.rd_data), 32'(mq[0]));
    end
  end

  // One clock: apply inputs, take the edge, settle 1 ns.
  task automatic cyc(input logic c, input logic we, input logic [W-1:0] wd, input logic re);
    clear   = c;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(if0.count), 0);
    chk("rst_empty", 32'(if0.empty), 1);
    chk("rst_ae", 32'(if0.almost_empty), 1);
    chk("rst_rd_valid", 32'(if0.rd_valid), 0);
    chk("rst_rd_data", 32'(if0.rd_data), 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // 1: fill, then overflow
    for (int i = 1; i <= 16; i++) cyc(0, 1, W'(i), 0);
    chk("t1_full", 32'(if0.full), 1);
    chk("t1_count", 32'(if0.count), 16);
    cyc(0, 1, 8'hAA, 0);
    chk("t1_ovf", 32'(if0.overflow), 1);
    chk("t1_count_hold", 32'(if0.count), 16);

    // 2: drain in order, then underflow
    for (int i = 1; i <= 16; i++) begin
      chk("t2_fwft_head", 32'(if1.rd_data), i);
      cyc(0, 0, 0, 1);
      chk("t2_rd_valid", 32'(if0.rd_valid), 1);
      chk("t2_rd_data", 32'(if0.rd_data), i);
    end
    chk("t2_empty", 32'(if0.empty), 1);
    cyc(0, 0, 0, 1);
    chk("t2_unf", 32'(if0.underflow), 1);
    chk("t2_no_valid", 32'(if0.rd_valid), 0);
    cyc(1, 0, 0, 0);
    chk("clr_ovf", 32'(if0.overflow), 0);
    chk("clr_unf", 32'(if0.underflow), 0);

    // 3: pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) cyc(0, 1, W'(8'h20 + 8'(r * 16 + i)), 0);
      for (int i = 0; i < 10; i++) begin
        cyc(0, 0, 0, 1);
        chk("t3_data", 32'(if0.rd_data), 32'h20 + 32'(r * 16 + i));
      end
    end
    chk("t3_count", 32'(if0.count), 0);

    // 4: simultaneous push/pop while full
    for (int i = 1; i <= 16; i++) cyc(0, 1, W'(8'h60 + 8'(i)), 0);
    cyc(0, 1, 8'h55, 1);
    chk("t4_count", 32'(if0.count), 16);
    chk("t4_ovf", 32'(if0.overflow), 0);
    chk("t4_head", 32'(if0.rd_data), 32'h61);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1);
    chk("t4_last", 32'(if0.rd_data), 32'h55);
    cyc(0, 0, 0, 0);

    // 5: thresholds and fall-through latency
    chk("t5_fwft_idle", 32'(if1.rd_valid), 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, W'(8'h80 + 8'(i)), 0);
      if (i == 1) begin
        chk("t5_fwft_valid", 32'(if1.rd_valid), 1);
        chk("t5_fwft_data", 32'(if1.rd_data), 32'h81);
      end
      if (i == 2)  chk("t5_ae_at2", 32'(if0.almost_empty), 1);
      if (i == 3)  chk("t5_ae_at3", 32'(if0.almost_empty), 0);
      if (i == 11) chk("t5_af_at11", 32'(if0.almost_full), 0);
      if (i == 12) chk("t5_af_at12", 32'(if0.almost_full), 1);
    end

    // 6: clear beats a same-cycle write
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, W'(i), 0);
    chk("t6_count7", 32'(if0.count), 7);
    cyc(1, 1, 8'hEE, 0);
    chk("t6_count", 32'(if0.count), 0);
    chk("t6_empty", 32'(if0.empty), 1);
    chk("t6_ovf", 32'(if0.overflow), 0);
    chk("t6_unf", 32'(if0.underflow), 0);

    // Async reset mid-burst, checked before the next edge
    for (int i = 0; i < 5; i++) cyc(0, 1, W'(8'hC0 + 8'(i)), (i > 2));
    wr_en = 1'b1;
    rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(if0.count), 0);
    chk("ar_empty", 32'(if0.empty), 1);
    chk("ar_rd_valid", 32'(if0.rd_valid), 0);
    chk("ar_rd_data", 32'(if0.rd_data), 0);
    chk("ar_fwft_valid", 32'(if1.rd_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
